// File: rtl/reu_pkg.sv
// Shared definitions for the REU transfer sequencer: transfer type codes,
// the sequencer state encoding and small state-classification helpers.
package reu_pkg;

  localparam logic [1:0] XT_STASH  = 2'b00;  // C64 -> REU
  localparam logic [1:0] XT_FETCH  = 2'b01;  // REU -> C64
  localparam logic [1:0] XT_SWAP   = 2'b10;  // exchange
  localparam logic [1:0] XT_VERIFY = 2'b11;  // compare

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARM,
    ST_REQ,
    ST_CRD,
    ST_RRD,
    ST_RWR,
    ST_CWR,
    ST_CMP,
    ST_DONE,
    ST_VERR
  } state_t;

  // First access of every byte: fetch starts on the RAM side, all others on the C64 side.
  function automatic state_t first_access(input logic [1:0] xt);
    return (xt == XT_FETCH) ? ST_RRD : ST_CRD;
  endfunction

  // States during which the bus is requested and Execute=0 aborts the transfer.
  function automatic logic is_busy(input state_t s);
    return (s == ST_REQ) || (s == ST_CRD) || (s == ST_RRD) ||
           (s == ST_RWR) || (s == ST_CWR) || (s == ST_CMP);
  endfunction

endpackage

// File: rtl/reu_dma_req.sv
// DMA request handshake: owns the registered nDMA line and decides when the
// bus may be used, i.e. after nDMA has been low long enough for the CPU RDY
// line to settle and while the VIC leaves the bus available (BA=1).
module reu_dma_req #(
  parameter int REQ_SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dma_next,   // keep the request asserted during the next cycle
  input  logic in_req,     // sequencer is currently waiting in REQ
  input  logic ba,
  output logic ndma,
  output logic granted     // first access may start at the coming edge
);

  localparam int CW = (REQ_SETTLE > 1) ? $clog2(REQ_SETTLE + 1) : 1;

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          ndma_reg;
  logic          settled;

  // The REQ cycle that ends at the coming edge is cycle cnt_reg+1 of the request.
  assign settled = (int'(cnt_reg) + 1) >= REQ_SETTLE;
  assign granted = in_req & settled & ba;
  assign ndma    = ndma_reg;

  // Count REQ cycles (saturating once settled), clear outside REQ.
  always_comb begin
    cnt_next = '0;
    if (in_req) begin
      cnt_next = settled ? cnt_reg : cnt_reg + CW'(1);
    end
  end

  // Request line and settle counter update on the falling edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      ndma_reg <= 1'b1;
    end else begin
      cnt_reg  <= cnt_next;
      ndma_reg <= ~dma_next;
    end
  end

endmodule

// File: rtl/reu_xfer_seq.sv
// REU DMA transfer sequencer. Runs stash/fetch/swap/verify byte sequences
// over the C64 bus and REU DRAM, one PHI2 cycle per access, and reports
// address-advance, completion and verify-error pulses to the register file.
// Every output is a register loaded from the state being entered.
module reu_xfer_seq
  import reu_pkg::*;
#(
  parameter int REQ_SETTLE = 2
) (
  input  logic       PHI2,
  input  logic       nReset,
  input  logic       Execute,
  input  logic       FF00Decode,
  input  logic       FF00Wr,
  input  logic [1:0] XferType,
  input  logic       Length1,
  input  logic       BA,
  input  logic [7:0] CDataIn,
  input  logic [7:0] RAMDIn,
  output logic       nDMA,
  output logic       CAddrOE,
  output logic       CRnW,
  output logic       CDataOE,
  output logic [7:0] CDataOut,
  output logic       RAMRD,
  output logic       RAMWR,
  output logic [7:0] RAMDOut,
  output logic       NextCA,
  output logic       NextREUA,
  output logic       XferEnd,
  output logic       VerifyErr
);

  state_t     state_reg, state_next;
  logic [1:0] xt_reg, xt_next;
  logic [7:0] clatch_reg, clatch_next;
  logic [7:0] rlatch_reg, rlatch_next;

  logic       caddr_oe_reg, caddr_oe_next;
  logic       crnw_reg, crnw_next;
  logic       cdata_oe_reg, cdata_oe_next;
  logic [7:0] cdata_out_reg, cdata_out_next;
  logic       ramrd_reg, ramrd_next;
  logic       ramwr_reg, ramwr_next;
  logic [7:0] ramdout_reg, ramdout_next;
  logic       next_reg, next_next;
  logic       xfer_end_reg, xfer_end_next;
  logic       verify_err_reg, verify_err_next;

  logic       byte_done;
  logic       dma_next;
  logic       granted;

  reu_dma_req #(
    .REQ_SETTLE (REQ_SETTLE)
  ) u_dma_req (
    .clk      (PHI2),
    .rst_n    (nReset),
    .dma_next (dma_next),
    .in_req   (state_reg == ST_REQ),
    .ba       (BA),
    .ndma     (nDMA),
    .granted  (granted)
  );

  // Next state, data latches and the output values for the state being entered.
  always_comb begin
    state_next      = state_reg;
    xt_next         = xt_reg;
    clatch_next     = clatch_reg;
    rlatch_next     = rlatch_reg;
    byte_done       = 1'b0;
    next_next       = 1'b0;
    caddr_oe_next   = 1'b0;
    crnw_next       = 1'b1;
    cdata_oe_next   = 1'b0;
    cdata_out_next  = 8'h00;
    ramrd_next      = 1'b0;
    ramwr_next      = 1'b0;
    ramdout_next    = 8'h00;
    xfer_end_next   = 1'b0;
    verify_err_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (Execute) begin
          xt_next    = XferType;
          state_next = FF00Decode ? ST_ARM : ST_REQ;
        end
      end
      ST_ARM: begin
        if (!Execute) begin
          state_next = ST_IDLE;
        end else if (FF00Wr) begin
          xt_next    = XferType;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (granted) state_next = first_access(xt_reg);
      end
      // A C64 access only completes in a cycle that actually drove the bus
      // (strobe register high) and still had BA=1 at its end; a cycle lost to
      // BA=0 is replayed once BA returns.
      ST_CRD: begin
        if (BA && caddr_oe_reg) begin
          clatch_next = CDataIn;
          state_next  = (xt_reg == XT_STASH) ? ST_RWR : ST_RRD;
        end
      end
      ST_RRD: begin
        rlatch_next = RAMDIn;
        case (xt_reg)
          XT_FETCH: state_next = ST_CWR;
          XT_SWAP:  state_next = ST_RWR;
          default:  state_next = ST_CMP;
        endcase
      end
      ST_RWR: begin
        if (xt_reg == XT_STASH) byte_done = 1'b1;
        else                    state_next = ST_CWR;
      end
      ST_CWR: begin
        if (BA && caddr_oe_reg) byte_done = 1'b1;
      end
      ST_CMP: begin
        if (clatch_reg != rlatch_reg) state_next = ST_VERR;
        else                          byte_done  = 1'b1;
      end
      default: state_next = ST_IDLE;  // DONE, VERR
    endcase

    // Final byte ends the transfer; otherwise the advance pulse rides along
    // with the first access of the next byte.
    if (byte_done) begin
      if (Length1) begin
        state_next = ST_DONE;
      end else begin
        state_next = first_access(xt_reg);
        next_next  = 1'b1;
      end
    end

    // Dropping Execute mid-transfer releases the bus without an end pulse.
    if (!Execute && is_busy(state_reg)) begin
      state_next = ST_IDLE;
      next_next  = 1'b0;
    end

    case (state_next)
      ST_CRD: begin
        caddr_oe_next = BA;
      end
      ST_CWR: begin
        caddr_oe_next  = BA;
        crnw_next      = ~BA;
        cdata_oe_next  = BA;
        cdata_out_next = rlatch_next;
      end
      ST_RRD: ramrd_next = 1'b1;
      ST_RWR: begin
        ramwr_next   = 1'b1;
        ramdout_next = clatch_next;
      end
      ST_DONE: xfer_end_next   = 1'b1;
      ST_VERR: verify_err_next = 1'b1;
      default: ;
    endcase

    dma_next = is_busy(state_next);
  end

  // State, latches and registered outputs, all on the falling edge of PHI2.
  always_ff @(negedge PHI2 or negedge nReset) begin
    if (!nReset) begin
      state_reg      <= ST_IDLE;
      xt_reg         <= 2'b00;
      clatch_reg     <= 8'h00;
      rlatch_reg     <= 8'h00;
      caddr_oe_reg   <= 1'b0;
      crnw_reg       <= 1'b1;
      cdata_oe_reg   <= 1'b0;
      cdata_out_reg  <= 8'h00;
      ramrd_reg      <= 1'b0;
      ramwr_reg      <= 1'b0;
      ramdout_reg    <= 8'h00;
      next_reg       <= 1'b0;
      xfer_end_reg   <= 1'b0;
      verify_err_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      xt_reg         <= xt_next;
      clatch_reg     <= clatch_next;
      rlatch_reg     <= rlatch_next;
      caddr_oe_reg   <= caddr_oe_next;
      crnw_reg       <= crnw_next;
      cdata_oe_reg   <= cdata_oe_next;
      cdata_out_reg  <= cdata_out_next;
      ramrd_reg      <= ramrd_next;
      ramwr_reg      <= ramwr_next;
      ramdout_reg    <= ramdout_next;
      next_reg       <= next_next;
      xfer_end_reg   <= xfer_end_next;
      verify_err_reg <= verify_err_next;
    end
  end

  assign CAddrOE   = caddr_oe_reg;
  assign CRnW      = crnw_reg;
  assign CDataOE   = cdata_oe_reg;
  assign CDataOut  = cdata_out_reg;
  assign RAMRD     = ramrd_reg;
  assign RAMWR     = ramwr_reg;
  assign RAMDOut   = ramdout_reg;
  assign NextCA    = next_reg;
  assign NextREUA  = next_reg;
  assign XferEnd   = xfer_end_reg;
  assign VerifyErr = verify_err_reg;

endmodule

// File: tb/tb_reu_xfer_seq.sv
// Directed bench for the REU transfer sequencer. Expected bus events are
// queued before each transfer and matched in order by a posedge monitor.
module tb_reu_xfer_seq;

  logic       PHI2, nReset, Execute, FF00Decode, FF00Wr, Length1, BA;
  logic [1:0] XferType;
  logic [7:0] CDataIn, RAMDIn;
  logic       nDMA, CAddrOE, CRnW, CDataOE, RAMRD, RAMWR;
  logic       NextCA, NextREUA, XferEnd, VerifyErr;
  logic [7:0] CDataOut, RAMDOut;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  localparam logic [7:0] EV_NEXT = 8'h01;
  localparam logic [7:0] EV_CRD  = 8'h02;
  localparam logic [7:0] EV_RRD  = 8'h03;
  localparam logic [7:0] EV_RWR  = 8'h04;
  localparam logic [7:0] EV_CWR  = 8'h05;
  localparam logic [7:0] EV_END  = 8'h06;
  localparam logic [7:0] EV_VERR = 8'h07;

  reu_xfer_seq dut (
    .PHI2(PHI2), .nReset(nReset), .Execute(Execute), .FF00Decode(FF00Decode),
    .FF00Wr(FF00Wr), .XferType(XferType), .Length1(Length1), .BA(BA),
    .CDataIn(CDataIn), .RAMDIn(RAMDIn), .nDMA(nDMA), .CAddrOE(CAddrOE),
    .CRnW(CRnW), .CDataOE(CDataOE), .CDataOut(CDataOut), .RAMRD(RAMRD),
    .RAMWR(RAMWR), .RAMDOut(RAMDOut), .NextCA(NextCA), .NextREUA(NextREUA),
    .XferEnd(XferEnd), .VerifyErr(VerifyErr)
  );

  initial PHI2 = 1'b1;
  always #5 PHI2 = ~PHI2;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ex(input logic [7:0] kind, input logic [7:0] data);
    exp_q.push_back({kind, data});
  endtask

  task automatic sb_check(input logic [15:0] ev);
    logic [15:0] exp;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
    $display("event %h expected %h", ev, exp);
    chk("scoreboard", ev, exp);
  endtask

  // Monitor: turn each observed bus cycle / pulse into a scoreboard event.
  always @(posedge PHI2) begin
    if (NextCA || NextREUA)              sb_check({EV_NEXT, 6'b0, NextCA, NextREUA});
    if (CAddrOE && CRnW)                 sb_check({EV_CRD, 8'h00});
    if (RAMRD)                           sb_check({EV_RRD, 8'h00});
    if (RAMWR)                           sb_check({EV_RWR, RAMDOut});
    if (CDataOE || (CAddrOE && !CRnW))   sb_check({EV_CWR, CDataOut});
    if (XferEnd)                         sb_check({EV_END, 8'h00});
    if (VerifyErr)                       sb_check({EV_VERR, 8'h00});
  end

  // Run a transfer of nbytes; Length1 follows the advance pulses like the register file would.
  task automatic run_xfer(input int nbytes, input int max_cyc);
    int nexts;
    bit done;
    nexts = 0;
    done = 1'b0;
    Length1 = (nbytes == 1);
    Execute = 1'b1;
    for (int c = 0; c < max_cyc && !done; c++) begin
      @(posedge PHI2);
      if (NextCA) begin
        nexts++;
        if (nexts == nbytes - 1) Length1 = 1'b1;
      end
      if (XferEnd || VerifyErr) begin
        done = 1'b1;
        chk("end_ndma", {15'b0, nDMA}, 16'h0001);
        chk("end_excl", {15'b0, XferEnd & VerifyErr}, 16'h0000);
        Execute = 1'b0;
      end
    end
    chk("xfer_done", {15'b0, done}, 16'h0001);
    Execute = 1'b0;
    @(posedge PHI2);
    @(posedge PHI2);
    chk("sb_empty", 16'(exp_q.size()), 16'h0000);
    chk("idle_ndma", {15'b0, nDMA}, 16'h0001);
  endtask

  initial begin
    bit found;
    nReset = 1'b1; Execute = 1'b0; FF00Decode = 1'b0; FF00Wr = 1'b0;
    XferType = 2'b00; Length1 = 1'b0; BA = 1'b1; CDataIn = 8'h00; RAMDIn = 8'h00;
    #1 nReset = 1'b0;
    repeat (2) @(posedge PHI2);
    chk("rst_ndma", {15'b0, nDMA}, 16'h0001);
    chk("rst_crnw", {15'b0, CRnW}, 16'h0001);
    chk("rst_strobes", {10'b0, CAddrOE, CDataOE, RAMRD, RAMWR, NextCA, NextREUA}, 16'h0000);
    chk("rst_pulses", {14'b0, XferEnd, VerifyErr}, 16'h0000);
    chk("rst_data", {CDataOut, RAMDOut}, 16'h0000);
    nReset = 1'b1;
    @(posedge PHI2);

    // Stash, single byte
    XferType = 2'b00; CDataIn = 8'hA5;
    ex(EV_CRD, 8'h00); ex(EV_RWR, 8'hA5); ex(EV_END, 8'h00);
    run_xfer(1, 40);

    // Fetch, three bytes
    XferType = 2'b01; RAMDIn = 8'h3C;
    for (int b = 0; b < 3; b++) begin
      if (b > 0) ex(EV_NEXT, 8'h03);
      ex(EV_RRD, 8'h00); ex(EV_CWR, 8'h3C);
    end
    ex(EV_END, 8'h00);
    run_xfer(3, 60);

    // Swap, single byte
    XferType = 2'b10; CDataIn = 8'h12; RAMDIn = 8'h34;
    ex(EV_CRD, 8'h00); ex(EV_RRD, 8'h00); ex(EV_RWR, 8'h12); ex(EV_CWR, 8'h34); ex(EV_END, 8'h00);
    run_xfer(1, 40);

    // Verify mismatch
    XferType = 2'b11; CDataIn = 8'h55; RAMDIn = 8'h56;
    ex(EV_CRD, 8'h00); ex(EV_RRD, 8'h00); ex(EV_VERR, 8'h00);
    run_xfer(1, 40);

    // Verify match over two bytes
    CDataIn = 8'h77; RAMDIn = 8'h77;
    ex(EV_CRD, 8'h00); ex(EV_RRD, 8'h00);
    ex(EV_NEXT, 8'h03); ex(EV_CRD, 8'h00); ex(EV_RRD, 8'h00); ex(EV_END, 8'h00);
    run_xfer(2, 40);

    // Deferred start via $FF00
    FF00Decode = 1'b1; XferType = 2'b00; CDataIn = 8'hC3; Length1 = 1'b1; Execute = 1'b1;
    ex(EV_CRD, 8'h00); ex(EV_RWR, 8'hC3); ex(EV_END, 8'h00);
    repeat (3) begin
      @(posedge PHI2);
      chk("arm_ndma", {15'b0, nDMA}, 16'h0001);
    end
    FF00Wr = 1'b1;
    @(posedge PHI2);
    FF00Wr = 1'b0;
    chk("ff00_ndma", {15'b0, nDMA}, 16'h0000);
    run_xfer(1, 40);
    FF00Decode = 1'b0;

    // BA stall during CWR of a swap
    XferType = 2'b10; CDataIn = 8'h9A; RAMDIn = 8'hBC; Length1 = 1'b1; Execute = 1'b1;
    ex(EV_CRD, 8'h00); ex(EV_RRD, 8'h00); ex(EV_RWR, 8'h9A); ex(EV_CWR, 8'hBC);
    ex(EV_CWR, 8'hBC); ex(EV_END, 8'h00);
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(posedge PHI2);
      if (CDataOE) found = 1'b1;
    end
    chk("cwr_seen", {15'b0, found}, 16'h0001);
    BA = 1'b0;
    repeat (3) begin
      @(posedge PHI2);
      chk("stall_strobes", {13'b0, CAddrOE, CDataOE, CRnW}, 16'h0001);
      chk("stall_ndma", {15'b0, nDMA}, 16'h0000);
    end
    BA = 1'b1;
    run_xfer(1, 40);

    // Asynchronous reset in the middle of a swap
    XferType = 2'b10; CDataIn = 8'h11; RAMDIn = 8'h22; Length1 = 1'b1; Execute = 1'b1;
    ex(EV_CRD, 8'h00); ex(EV_RRD, 8'h00);
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(posedge PHI2);
      if (RAMRD) found = 1'b1;
    end
    chk("rrd_seen", {15'b0, found}, 16'h0001);
    #1 nReset = 1'b0;
    #1;
    chk("mid_rst_ndma", {15'b0, nDMA}, 16'h0001);
    chk("mid_rst_strobes", {13'b0, RAMRD, CAddrOE, RAMWR}, 16'h0000);
    Execute = 1'b0;
    @(posedge PHI2);
    nReset = 1'b1;
    repeat (3) @(posedge PHI2);
    chk("post_rst_ndma", {15'b0, nDMA}, 16'h0001);
    chk("post_rst_sb", 16'(exp_q.size()), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
